// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared core types and constants for the fetch stage and the
//               branch-target unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST_WORD        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Sequential-PC increment; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_add4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_register.sv
// ============================================================================
// Module      : fetch_unit_pc_register
// Description : 32-bit program counter with async reset to RESET_VECTOR,
//               load enable, and combinational pc+4 output.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit_pc_register
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_4
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc   = pc_q;
    assign pc_4 = pc_add4(pc_q);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : PC register and req/ack instruction-fetch stage with a
//               valid/ready hand-off to decode. Optional macro
//               MISALIGN_TRAP_EN adds a sticky HALT on misaligned next PC.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] NOP_INST     = NOP_INST_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc_in,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_4_out,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] retired_cnt,
    output logic            misalign_err
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] retired_q, retired_d;
    logic            load_en;
    logic [XLEN-1:0] load_pc;
    logic            misaligned;

`ifdef MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;

    // The raw target is kept so the faulting address is visible on pc_out.
    assign load_pc    = next_pc_in;
    assign misaligned = (next_pc_in[1:0] != 2'b00);
`else
    assign load_pc    = next_pc_in & ~32'h0000_0003;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        valid_d   = valid_q;
        retired_d = retired_q;
        load_en   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    load_en   = 1'b1;
                    inst_d    = NOP_INST;
                    valid_d   = 1'b0;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                    if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
`endif
                    end
                end
            end
            ST_HALT: begin
`ifdef MISALIGN_TRAP_EN
                state_d = ST_HALT;
`else
                state_d = ST_BOOT;
`endif
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            inst_q    <= NOP_INST;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    fetch_unit_pc_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_register (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .load_pc (load_pc),
        .pc      (pc_out),
        .pc_4    (pc_4_out)
    );

    // Decoded straight from state so an async reset drops the request at once.
    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_out;
    assign inst_out    = inst_q;
    assign inst_valid  = valid_q;
    assign retired_cnt = retired_q;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC register and instruction-fetch stage directly upstream of the branch-target unit.
- Holds the current PC and issues a request/acknowledge fetch to instruction memory.
- Presents inst/pc/pc_4 to decode and the branch-target unit with a valid/ready handshake.
- Loads the next PC (the branch-target unit's address output) when the held instruction is consumed.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
NOP_INST, 32'h0000_0013, value on inst_out while no fetched instruction is held (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
next_pc_in  input  32  next PC from branch-target unit, sampled on consume
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; equals pc_out
imem_ack  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
inst_out  output  32  held instruction to decode / branch-target unit
pc_out  output  32  PC of inst_out
pc_4_out  output  32  pc_out + 4
inst_valid  output  1  inst_out/pc_out valid
inst_ready  input  1  downstream consumes the held instruction
retired_cnt  output  32  count of consumed instructions
misalign_err  output  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - pc_out = RESET_VECTOR; pc_4_out = RESET_VECTOR+4; inst_out = NOP_INST.
  - inst_valid = 0; imem_req = 0; retired_cnt = 0; misalign_err = 0; state = BOOT.
  - An outstanding memory request is abandoned; an ack arriving after reset release while in BOOT is ignored.
- FSM states: BOOT, FETCH, HOLD (HALT with the feature).
- BOOT: one cycle with imem_req = 0, then unconditionally -> FETCH.
- FETCH:
  - imem_req = 1; imem_addr = pc_out, stable until ack.
  - On a clock edge with imem_ack = 1: inst_out <= imem_rdata, inst_valid <= 1, -> HOLD.
  - Otherwise stay in FETCH with the request held; there is no timeout.
- HOLD:
  - imem_req = 0; inst_valid = 1; inst_out/pc_out/pc_4_out stable.
  - imem_ack in HOLD is ignored.
  - On an edge with inst_ready = 1: pc_out <= next_pc_in, pc_4_out <= next_pc_in + 4, inst_valid <= 0, retired_cnt <= retired_cnt + 1, -> FETCH.
  - inst_ready while not in HOLD is ignored.
- Throughput: at best one instruction per 2 cycles (ack in the first FETCH cycle, ready in the first HOLD cycle). Latency from reset release to first inst_valid is at least 2 cycles.
- Arithmetic:
  - pc_4_out is a 32-bit add that wraps: 0xFFFF_FFFC -> 0x0000_0000.
  - retired_cnt wraps: 0xFFFF_FFFF -> 0.
- next_pc_in is only sampled on the consume edge; the downstream branch-target unit computes it combinationally from inst_out/pc_out/pc_4_out during HOLD.
- Without the feature, bits [1:0] of next_pc_in are forced to 0 when loaded.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - On a consume edge with next_pc_in[1:0] != 0: pc_out is still loaded with the raw value, misalign_err <= 1, state -> HALT, retired_cnt still increments.
  - HALT: imem_req = 0, inst_valid = 0; exited only by rst.
- Undefined: no HALT state; bits [1:0] are forced to 0; misalign_err is constant 0.

Decomposition:
- Shared core package holds:
  - the fetch state enum (BOOT/FETCH/HOLD/HALT);
  - the NOP_INST constant;
  - the default RESET_VECTOR;
  - the 32-bit XLEN width constant used by the branch-target unit.
- One natural sub-module: pc_register. It is a 32-bit register with asynchronous reset to RESET_VECTOR and a load enable, and it outputs pc and pc+4.

Test Plan:
- Reset release, imem_ack = 1 on the first FETCH cycle, rdata = 0x00500093 -> imem_req seen at cycle 2 with addr 0x0; inst_valid at cycle 3 with inst_out 0x00500093, pc_out 0x0, pc_4_out 0x4.
- Ack delayed 5 cycles -> imem_req and imem_addr held stable for all 5 cycles; inst_valid stays 0; no PC change.
- HOLD with inst_ready low for 3 cycles, next_pc_in toggling -> outputs stable; then ready with next_pc_in = 0x40 -> next fetch addr 0x40; retired_cnt = 1.
- next_pc_in = 0xFFFF_FFFC on consume -> pc_out 0xFFFF_FFFC, pc_4_out 0x0.
- rst asserted mid-FETCH -> imem_req drops asynchronously; pc_out returns to RESET_VECTOR; a stray ack in BOOT leaves inst_valid = 0.
- next_pc_in = 0x0000_0042: with MISALIGN_TRAP_EN -> misalign_err = 1, imem_req stays 0 until rst; without it -> fetch addr 0x0000_0040.
